dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Memory-side responder for MEM-stage loads/stores: accepts one request at a time, drives a
//  word-wide synchronous data SRAM without byte enables, and returns aligned and extended load data.
//  Sub-word stores (sb/sh) use read-modify-write. Misaligned or invalid requests are rejected
//  with an error response. Sits between the pipeline's MEM stage and the data RAM.
// PARAMETERS
//  ADDR_W  11  SRAM word-address width; ram_addr = req_addr[ADDR_W+1:2], upper bits ignored (wrap)
//  RD_LAT  1   SRAM read latency in cycles (legal 1..2); ram_rdata valid RD_LAT cycles after ram_en&!ram_we
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_instr  in   8       one-hot: b0 lb, b1 lbu, b2 lh, b3 lhu, b4 lw, b5 sb, b6 sh, b7 sw
//  req_addr   in   32      byte address
//  req_wdata  in   32      store data (rt register value)
//  req_ready  out  1       1 only in IDLE; accept = req_valid & req_ready at rising edge
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_rdata  out  32      load result, valid with rsp_valid; 0 for stores and errors
//  rsp_err    out  1       misaligned or invalid request, valid with rsp_valid
//  ram_en     out  1       SRAM access strobe
//  ram_we     out  1       SRAM write (full 32-bit word)
//  ram_addr   out  ADDR_W  SRAM word address
//  ram_wdata  out  32      SRAM write data
//  ram_rdata  in   32      SRAM read data
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; req_ready=1; all other outputs 0; the request register is cleared.
//  - Accept latches req_instr/addr/wdata. ram_* and rsp_* are decoded from state and latched fields only.
//    There is no combinational path from req_* to any output except req_ready, which is state-only.
//  - FSM: IDLE, RD, WAIT, WR, RESP.
//    IDLE: accept. Error goes to RESP. sw goes to WR. Loads and sb/sh go to RD.
//    RD: ram_en=1, ram_we=0, one cycle, then WAIT.
//    WAIT: lasts RD_LAT cycles. ram_rdata is captured at the end of the last WAIT cycle.
//      Then loads go to RESP and sb/sh go to WR.
//    WR: ram_en=1, ram_we=1, ram_wdata = merged word (sb/sh) or latched wdata (sw), one cycle, then RESP.
//    RESP: rsp_valid=1 for one cycle, then IDLE.
//  - Latency, with the accept edge ending cycle 0: rsp_valid is high in
//    loads cycle 2+RD_LAT; sw cycle 2; sb/sh cycle 3+RD_LAT; error cycle 1.
//  - Load extract, lane = addr[1:0]:
//    lb/lbu take byte lane (lane*8+7:lane*8), sign-/zero-extended.
//    lh/lhu take [15:0] if addr[1]=0, otherwise [31:16], sign-/zero-extended.
//    lw takes the whole word.
//  - Store merge:
//    sb replaces byte lane with wdata[7:0].
//    sh replaces half addr[1] with wdata[15:0].
//    All other bits come from the captured word.
//  - Error: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0, or req_instr not exactly one-hot (incl. 0).
//    Response: rsp_err=1, rsp_rdata=0, no RAM access.
//  - Exactly one ram_en per load or sw, two per sb/sh, and at most one ram_we per request.
//  - req_valid held high during a transaction is ignored until back in IDLE.
//    Throughput is one request per (latency+1) cycles.
//  - Reset mid-operation abandons the request: no later ram_en/ram_we and no rsp_valid.
//    A WR cycle already completed before reset is not undone.
// STRUCTURE
//  - Package dmem_pkg holds:
//    instr one-hot constants (LB=8'h01 .. SW=8'h80);
//    the FSM state enum;
//    functions is_load, is_subword_store, misaligned.
//  - Sub-module dmem_lane_align (combinational): extract(rdata, instr, lane) and
//    merge(rdata, wdata, instr, lane). The FSM, counter and registers stay in dmem_access_ctrl.
// TESTING (behavioural SRAM model, RD_LAT=1 unless stated; word 0x40 = byte addr 0x100)
//  1. lb 0x103, mem[0x40]=0x80FF1234 -> rsp_rdata=0xFFFFFF80, rsp_err=0, rsp_valid in cycle 3,
//     one read, no write.
//  2. sb 0x101, wdata=0x000000AB, mem[0x40]=0x11223344 -> read then single write 0x1122AB44 to 0x40,
//     rsp_valid in cycle 4.
//  3. sh 0x102, wdata=0xCAFEBEEF, mem=0x11223344 -> write 0xBEEF3344.
//     sw 0x100, wdata=0x12345678 -> write in cycle 1, rsp_valid in cycle 2.
//  4. lw 0x102, lh 0x101, req_instr=8'h03 -> each: rsp_err=1, rsp_rdata=0, rsp_valid in cycle 1,
//     ram_en never asserted.
//  5. rst_n low during WAIT of sb -> no ram_we and no rsp_valid. After release: req_ready=1,
//     and lw 0x100 returns the unmodified word.
//  6. RD_LAT=2, req_valid held high with lhu 0x106 then lbu 0x107, mem[0x41]=0x80010000
//     -> 0x00008001 in cycle 4, 0x00000080 accepted in cycle 5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: one-hot instruction
// codes, FSM state encoding and request classification helpers.
package dmem_pkg;

    localparam logic [7:0] LB  = 8'h01;
    localparam logic [7:0] LBU = 8'h02;
    localparam logic [7:0] LH  = 8'h04;
    localparam logic [7:0] LHU = 8'h08;
    localparam logic [7:0] LW  = 8'h10;
    localparam logic [7:0] SB  = 8'h20;
    localparam logic [7:0] SH  = 8'h40;
    localparam logic [7:0] SW  = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StResp
    } state_e;

    function automatic logic is_load(input logic [7:0] instr);
        return |(instr & (LB | LBU | LH | LHU | LW));
    endfunction

    function automatic logic is_subword_store(input logic [7:0] instr);
        return |(instr & (SB | SH));
    endfunction

    function automatic logic is_onehot(input logic [7:0] instr);
        return (instr != 8'h00) && ((instr & (instr - 8'h01)) == 8'h00);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic misaligned(input logic [7:0] instr, input logic [1:0] lane);
        return ((|(instr & (LH | LHU | SH))) && lane[0]) ||
               ((|(instr & (LW | SW))) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane alignment: extracts and extends load data from a
// memory word, and builds the full word to write back for stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [7:0]  instr,
    input  logic [1:0]  lane,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load extract: pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = '0;
        case (instr)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'h000000, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'h0000, half_sel};
            LW:      load_data = rdata;
            default: load_data = '0;
        endcase
    end

    // Store merge: overlay the store bytes onto the word read back from RAM.
    always_comb begin
        store_data = rdata;
        case (instr)
            SB: store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            SH: begin
                if (lane[1]) begin
                    store_data[31:16] = wdata[15:0];
                end else begin
                    store_data[15:0] = wdata[15:0];
                end
            end
            SW:      store_data = wdata;
            default: store_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory responder: one request at a time, read-modify-write for
// sub-word stores, error response for misaligned or malformed requests.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [7:0]        req_instr,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    import dmem_pkg::*;

    localparam logic [1:0] LastWait = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        instr_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept;
    logic              req_err;
    logic              capture;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    // Address bits above the RAM window wrap and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign accept  = req_valid & req_ready;
    assign req_err = !is_onehot(req_instr) || misaligned(req_instr, req_addr[1:0]);

    dmem_lane_align u_lane_align (
        .rdata      (rdata_q),
        .wdata      (wdata_q),
        .instr      (instr_q),
        .lane       (addr_q[1:0]),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // State, wait counter and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                instr_q <= req_instr;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (capture) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    // Next-state logic; the RAM word is captured on the last WAIT cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_instr == SW) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == LastWait) begin
                    capture = 1'b1;
                    state_d = is_subword_store(instr_q) ? StWr : StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and latched fields only.
    always_comb begin
        req_ready = (state_q == StIdle);
        ram_en    = (state_q == StRd) || (state_q == StWr);
        ram_we    = (state_q == StWr);
        ram_addr  = addr_q[ADDR_W+1:2];
        ram_wdata = (state_q == StWr) ? store_data : '0;
        rsp_valid = (state_q == StResp);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q) ? load_data : '0;
    end

endmodule
